// File: rtl/mem_rr_arbiter_if.sv
// Native picorv32 valid/ready memory bus, N_PORTS lanes wide; the read data is shared by all lanes.
interface mem_rr_arbiter_if #(
  parameter int unsigned N_PORTS = 1
) ();
  logic [N_PORTS-1:0]    valid;
  logic [32*N_PORTS-1:0] addr;
  logic [32*N_PORTS-1:0] wdata;
  logic [4*N_PORTS-1:0]  wstrb;
  logic [N_PORTS-1:0]    ready;
  logic [31:0]           rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_rr_arbiter.sv
// Request-driven round-robin arbiter sharing one memory slave between N_PORTS cores,
// with a per-transaction timeout that completes a hung access and flags the port.
module mem_rr_arbiter #(
  parameter int unsigned N_PORTS        = 4,
  parameter int unsigned PORT_BITS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  mem_rr_arbiter_if.slave      req,
  mem_rr_arbiter_if.master     mem,
  output logic [PORT_BITS-1:0] grant_id,
  output logic                 busy,
  output logic [N_PORTS-1:0]   err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [PORT_BITS-1:0] ptr, gnt_idx;
  logic                 gnt_found;
  logic [CNT_W-1:0]     cnt;
  logic                 timeout_hit;
  logic [31:0]          addr_q, wdata_q, rdata_q;
  logic [3:0]           wstrb_q;
  int unsigned          srch_j;

  // First requesting port at or above the pointer, wrapping modulo N_PORTS.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    srch_j    = 0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      srch_j = (32'(ptr) + i) % N_PORTS;
      if (!gnt_found && req.valid[srch_j]) begin
        gnt_found = 1'b1;
        gnt_idx   = PORT_BITS'(srch_j);
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = ISSUE;
      ISSUE:   if (mem.ready[0] || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr      <= '0;
      grant_id <= '0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      err      <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_found) begin
          addr_q   <= req.addr[32*gnt_idx +: 32];
          wdata_q  <= req.wdata[32*gnt_idx +: 32];
          wstrb_q  <= req.wstrb[4*gnt_idx +: 4];
          grant_id <= gnt_idx;
          ptr      <= PORT_BITS'((32'(gnt_idx) + 1) % N_PORTS);
          cnt      <= '0;
        end
        ISSUE: begin
          // A same-cycle mem_ready wins over the timeout.
          if (mem.ready[0]) begin
            rdata_q <= mem.rdata;
          end else if (timeout_hit) begin
            rdata_q       <= '0;
            err[grant_id] <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem.valid = state == ISSUE;
    mem.addr  = addr_q;
    mem.wdata = wdata_q;
    mem.wstrb = wstrb_q;
    busy      = state != IDLE;
    req.ready = '0;
    if (state == RESP) req.ready[grant_id] = 1'b1;
    req.rdata = rdata_q;
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/responses, monitors pop them as the DUTs present them.
module tb_mem_rr_arbiter;

  typedef struct { int port; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } iss_t;
  typedef struct { int port; logic [31:0] rdata; } rsp_t;
  typedef struct { int port; logic [31:0] rdata; logic [3:0] err; int cyc; } trsp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.N_PORTS(4)) r ();
  mem_rr_arbiter_if #(.N_PORTS(1)) m ();
  mem_rr_arbiter_if #(.N_PORTS(4)) tr ();
  mem_rr_arbiter_if #(.N_PORTS(1)) tm ();
  logic [1:0] grant_id, t_grant_id;
  logic       busy, t_busy;
  logic [3:0] err, t_err;

  mem_rr_arbiter #(.N_PORTS(4), .PORT_BITS(2), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .resetn(resetn), .req(r), .mem(m),
    .grant_id(grant_id), .busy(busy), .err(err));

  mem_rr_arbiter #(.N_PORTS(4), .PORT_BITS(2), .TIMEOUT_CYCLES(4)) tdut (
    .clk(clk), .resetn(resetn), .req(tr), .mem(tm),
    .grant_id(t_grant_id), .busy(t_busy), .err(t_err));

  int    n_tests = 0;
  int    n_fail  = 0;
  iss_t  iq[$];
  rsp_t  rq[$];
  trsp_t tq[$];
  int    left[4];
  int    n_resp = 0;
  bit    chk_gap = 0;
  int    last_rise = -1;
  int    cyc = 0;

  bit          s_never = 0, s_ovr = 0, t_never = 0;
  int          s_wait = 0, t_wait = 0;
  logic [31:0] s_data = '0, t_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_issue(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    iss_t it;
    it.port = p; it.addr = a; it.wdata = d; it.wstrb = s;
    iq.push_back(it);
  endtask

  task automatic exp_resp(input int p, input logic [31:0] d);
    rsp_t it;
    it.port = p; it.rdata = d;
    rq.push_back(it);
  endtask

  task automatic exp_tresp(input int p, input logic [31:0] d, input logic [3:0] e, input int c);
    trsp_t it;
    it.port = p; it.rdata = d; it.err = e; it.cyc = c;
    tq.push_back(it);
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int n);
    r.addr[32*k +: 32]  = a;
    r.wdata[32*k +: 32] = d;
    r.wstrb[4*k +: 4]   = s;
    left[k]             = n;
    r.valid[k]          = 1'b1;
  endtask

  task automatic tset_req(input int k, input logic [31:0] a);
    tr.addr[32*k +: 32]  = a;
    tr.wdata[32*k +: 32] = '0;
    tr.wstrb[4*k +: 4]   = '0;
    tr.valid[k]          = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (r.valid == 0 && !busy) done = 1;
    end
    if (!done) chk("wait_idle_timeout", {busy, r.valid}, 0);
  endtask

  task automatic twait_idle(input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (tr.valid == 0 && !t_busy) done = 1;
    end
    if (!done) chk("twait_idle_timeout", {t_busy, tr.valid}, 0);
  endtask

  // Slave models: answer after s_wait/t_wait extra cycles unless told to hang.
  initial begin
    int wcnt = 0;
    m.ready = '0; m.rdata = '0;
    forever begin
      @(negedge clk);
      if (m.valid[0] && !s_never && wcnt == s_wait) begin
        m.ready = 1'b1;
        m.rdata = s_ovr ? s_data : (m.addr ^ 32'hC0DE_0000);
        wcnt = 0;
      end else begin
        m.ready = 1'b0;
        wcnt = m.valid[0] ? wcnt + 1 : 0;
      end
    end
  end

  initial begin
    int wcnt = 0;
    tm.ready = '0; tm.rdata = '0;
    forever begin
      @(negedge clk);
      if (tm.valid[0] && !t_never && wcnt == t_wait) begin
        tm.ready = 1'b1;
        tm.rdata = t_data;
        wcnt = 0;
      end else begin
        tm.ready = 1'b0;
        wcnt = tm.valid[0] ? wcnt + 1 : 0;
      end
    end
  end

  // Core models: drop valid after the requested number of completions.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      if (r.ready[k] && left[k] > 0) begin
        left[k]--;
        if (left[k] == 0) r.valid[k] = 1'b0;
      end
    for (int k = 0; k < 4; k++)
      if (tr.ready[k]) tr.valid[k] = 1'b0;
  end

  initial begin
    bit   prev_mv = 0;
    iss_t cur;
    rsp_t rs;
    forever begin
      @(negedge clk);
      cyc++;
      if (m.valid[0] && !prev_mv) begin
        if (iq.size() == 0) chk("issue_unexpected", m.valid, 0);
        else begin
          cur = iq.pop_front();
          chk("grant_id", grant_id, cur.port);
          chk("issue_fields", {m.addr, m.wdata, m.wstrb}, {cur.addr, cur.wdata, cur.wstrb});
          if (chk_gap && last_rise >= 0) chk("grant_gap", cyc - last_rise, 3);
          last_rise = cyc;
        end
      end else if (m.valid[0]) begin
        chk("issue_stable", {m.addr, m.wdata, m.wstrb}, {cur.addr, cur.wdata, cur.wstrb});
      end
      prev_mv = m.valid[0];
      if (r.ready != 0) begin
        n_resp++;
        if (rq.size() == 0) chk("resp_unexpected", r.ready, 0);
        else begin
          rs = rq.pop_front();
          chk("resp_port", r.ready, 4'b0001 << rs.port);
          chk("resp_rdata", r.rdata, rs.rdata);
        end
      end
    end
  end

  initial begin
    int    t_cyc = 0;
    trsp_t ts;
    forever begin
      @(negedge clk);
      if (tm.valid[0]) t_cyc++;
      if (tr.ready != 0) begin
        if (tq.size() == 0) chk("to_resp_unexpected", tr.ready, 0);
        else begin
          ts = tq.pop_front();
          chk("to_port", tr.ready, 4'b0001 << ts.port);
          chk("to_rdata", tr.rdata, ts.rdata);
          chk("to_err", t_err, ts.err);
          chk("to_issue_cycles", t_cyc, ts.cyc);
        end
      end
      if (!tm.valid[0]) t_cyc = 0;
    end
  end

  initial begin
    resetn = 1'b0;
    r.valid = '0; r.addr = '0; r.wdata = '0; r.wstrb = '0;
    tr.valid = '0; tr.addr = '0; tr.wdata = '0; tr.wstrb = '0;
    for (int k = 0; k < 4; k++) left[k] = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", m.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", r.ready, 0);
    chk("rst_rdata", r.rdata, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_err", err, 0);
    chk("rst_fields", {m.addr, m.wdata, m.wstrb}, 0);
    chk("rst_t_err", t_err, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single zero-wait read from port 2.
    s_ovr = 1; s_data = 32'hDEAD_BEEF;
    exp_issue(2, 32'h0000_0010, 32'h0, 4'h0);
    exp_resp(2, 32'hDEAD_BEEF);
    set_req(2, 32'h0000_0010, 32'h0, 4'h0, 1);
    @(negedge clk);
    chk("rd_issue_t1", m.valid, 1);
    chk("rd_noready_t1", r.ready, 0);
    @(negedge clk);
    chk("rd_ready_t2", r.ready, 4'b0100);
    chk("rd_rdata_t2", r.rdata, 32'hDEAD_BEEF);
    wait_idle(20);
    s_ovr = 0;

    // Write passthrough with a 5-cycle slave wait.
    s_wait = 5;
    exp_issue(1, 32'h1000_0000, 32'h0100_0001, 4'b1001);
    exp_resp(1, 32'hD0DE_0000);
    set_req(1, 32'h1000_0000, 32'h0100_0001, 4'b1001, 1);
    wait_idle(30);
    s_wait = 0;

    // Reset while port 3 is stuck in ISSUE, then re-grant.
    s_never = 1;
    exp_issue(3, 32'h0000_0030, 32'h0, 4'h0);
    exp_issue(3, 32'h0000_0030, 32'h0, 4'h0);
    exp_resp(3, 32'hC0DE_0030);
    set_req(3, 32'h0000_0030, 32'h0, 4'h0, 1);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_valid", m.valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", r.ready, 0);
    chk("mid_rst_grant", grant_id, 0);
    resetn = 1'b1;
    s_never = 0;
    wait_idle(20);

    // All four ports request together; port 0 asks twice.
    exp_issue(0, 32'h0000_0100, 32'h0, 4'h0);
    exp_issue(1, 32'h0000_0200, 32'h0, 4'h0);
    exp_issue(2, 32'h0000_0300, 32'h0, 4'h0);
    exp_issue(3, 32'h0000_0400, 32'h0, 4'h0);
    exp_issue(0, 32'h0000_0100, 32'h0, 4'h0);
    exp_resp(0, 32'hC0DE_0100);
    exp_resp(1, 32'hC0DE_0200);
    exp_resp(2, 32'hC0DE_0300);
    exp_resp(3, 32'hC0DE_0400);
    exp_resp(0, 32'hC0DE_0100);
    chk_gap = 1; last_rise = -1;
    set_req(0, 32'h0000_0100, 32'h0, 4'h0, 2);
    set_req(1, 32'h0000_0200, 32'h0, 4'h0, 1);
    set_req(2, 32'h0000_0300, 32'h0, 4'h0, 1);
    set_req(3, 32'h0000_0400, 32'h0, 4'h0, 1);
    wait_idle(60);
    chk_gap = 0;

    // Serve port 3 so the pointer wraps to 0, then ports 1 and 3 compete.
    exp_issue(3, 32'h0000_0430, 32'h0, 4'h0);
    exp_resp(3, 32'hC0DE_0430);
    set_req(3, 32'h0000_0430, 32'h0, 4'h0, 1);
    wait_idle(20);
    exp_issue(1, 32'h0000_0510, 32'h0, 4'h0);
    exp_issue(3, 32'h0000_0530, 32'h0, 4'h0);
    exp_resp(1, 32'hC0DE_0510);
    exp_resp(3, 32'hC0DE_0530);
    set_req(1, 32'h0000_0510, 32'h0, 4'h0, 1);
    set_req(3, 32'h0000_0530, 32'h0, 4'h0, 1);
    wait_idle(30);
    chk("err_none", err, 0);

    // Timeout instance: hang, recover, and a ready on the last allowed cycle.
    t_never = 1;
    exp_tresp(0, 32'h0, 4'b0001, 4);
    tset_req(0, 32'h0000_0040);
    twait_idle(30);
    t_never = 0; t_wait = 0; t_data = 32'h1234_5678;
    exp_tresp(0, 32'h1234_5678, 4'b0001, 1);
    tset_req(0, 32'h0000_0044);
    twait_idle(20);
    t_wait = 3; t_data = 32'hCAFE_F00D;
    exp_tresp(1, 32'hCAFE_F00D, 4'b0001, 4);
    tset_req(1, 32'h0000_0048);
    twait_idle(30);
    repeat (3) @(negedge clk);
    chk("err_sticky", t_err, 4'b0001);

    chk("iq_drained", iq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("tq_drained", tq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one memory/IO slave port between N_PORTS picorv32 cores using the native valid/ready memory interface.
- Replaces free-running slot counting with request-driven grants. Latency is fixed per transaction, and ports without requests cost no slots.
- Sits between the core array and the SoC memory/LED/UART decode logic.
- Adds a per-transaction timeout with sticky error flags so a hung slave cannot deadlock the cluster.

Parameters:
- N_PORTS, 4, number of requesting cores (2..8).
- PORT_BITS, 2, width of grant index; equals ceil(log2(N_PORTS)).
- TIMEOUT_CYCLES, 255, cycles in ISSUE before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  N_PORTS  per-port request; held until that port's req_ready
- req_addr  in  32*N_PORTS  per-port byte address; port k occupies bits [32k+31:32k]
- req_wdata  in  32*N_PORTS  per-port write data
- req_wstrb  in  4*N_PORTS  per-port byte strobes; 0 means read
- req_ready  out  N_PORTS  one-cycle completion pulse, one-hot
- req_rdata  out  32  read data shared by all ports; valid when any req_ready is high
- mem_valid  out  1  downstream request
- mem_addr  out  32  latched address of the granted port
- mem_wdata  out  32  latched write data
- mem_wstrb  out  4  latched strobes
- mem_ready  in  1  downstream completion; may be asserted in the same cycle mem_valid first rises
- mem_rdata  in  32  downstream read data, sampled when mem_ready is high
- grant_id  out  PORT_BITS  index of the current or last granted port
- busy  out  1  high in ISSUE or RESP
- err  out  N_PORTS  sticky timeout flag per port

Behaviour:
- Clock and reset: clock clk; reset resetn, synchronous, active-low.
- Reset values (all outputs and internal state): state=IDLE, mem_valid=0, mem_addr/wdata/wstrb=0, req_ready=0, req_rdata=0, grant_id=0, busy=0, err=0, rr pointer=0, timeout counter=0.
- Reset asserted mid-transaction: everything returns to the reset values at the next edge. No req_ready is issued for the in-flight request, and the slave sees mem_valid drop.
- IDLE: if any req_valid is set, grant g = first set bit searching upward from pointer p, wrapping modulo N_PORTS.
  - At the edge: latch port g's addr/wdata/wstrb, set grant_id=g and p=(g+1) mod N_PORTS, clear the timeout counter, mem_valid<=1, go to ISSUE.
  - If no request is pending, stay in IDLE and leave p unchanged.
- ISSUE: mem_valid=1 with the latched fields held stable.
  - mem_ready=1: capture mem_rdata into req_rdata, pulse req_ready[grant_id]=1 next cycle, mem_valid<=0, go to RESP.
  - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without mem_ready: req_rdata<=0, pulse req_ready[grant_id], set err[grant_id], mem_valid<=0, go to RESP.
  - Otherwise increment the counter.
  - mem_ready has priority over timeout when both occur in the same cycle.
- RESP: req_ready is high for exactly this cycle; next state is IDLE unconditionally. No grant is made in RESP, because the completing core's valid is still visible.
- Latency: req_valid seen at edge t gives mem_valid high in cycle t+1. A zero-wait slave (mem_ready in the first ISSUE cycle) gives req_ready in cycle t+2. The next grant is at edge t+3, so minimum occupancy is 3 cycles per transaction.
- Changes to req_valid, addr or data of the granted port after the grant are ignored until RESP. A request withdrawn by a non-granted port is simply not granted.
- Fairness: a port waits at most N_PORTS-1 other transactions between its request and its grant.
- Invariants: req_ready is one-hot or zero; mem_valid=0 outside ISSUE; err bits are cleared only by reset.
- Read vs write is not decoded; strobes pass through unmodified.

Test Plan:
- Single read: port 2 reads 0x0000_0010, slave returns 0xDEAD_BEEF with 0 wait → mem_valid at t+1 with mem_addr=0x10, wstrb=0; req_ready[2] and req_rdata=0xDEAD_BEEF at t+2; req_ready[0,1,3]=0.
- All four ports request continuously, zero-wait slave → grant order 0,1,2,3,0; grant every 3 cycles; no port is granted twice before the others are served.
- Pointer wrap: after port 3 is served, ports 1 and 3 request → port 1 is granted first (search starts from 0).
- Write passthrough: port 1 writes 0x1000_0000, wdata=0x0100_0001, wstrb=4'b1001 → mem_wdata and mem_wstrb match exactly, stable for a 5-cycle slave wait, and req_ready[1] fires once.
- Timeout with TIMEOUT_CYCLES=4 and a slave that never readies → req_ready[0] fires with req_rdata=0, err[0]=1 and stays 1. A later port-0 transaction succeeds normally while err[0] remains set. Also check that mem_ready on the 4th ISSUE cycle returns data and does not set err.
- Reset mid-ISSUE: resetn low for 1 cycle while port 3 waits → mem_valid=0, busy=0 and no req_ready pulse. With port 3 still requesting after reset, it is re-granted from pointer 0 (ports 0–2 idle).
